// File: rtl/counter_pkg.sv
// Shared counter types for the layer-datapath index sources.
package counter_pkg;

  // Two-state control for handshaked index counters.
  typedef enum logic {
    eIDLE  = 1'b0,
    eCOUNT = 1'b1
  } state_e;

endpackage : counter_pkg

// File: rtl/down_counter_handshake.sv
// Ready/valid index source: emits INPUT_MAX down to 0, one index per accepted
// beat, after a start pulse; finishes with a one-cycle done pulse.
// Optional feature macro AUTO_RESTART_EN: on the final beat, reload INPUT_MAX
// and keep streaming instead of returning to idle (done still pulses per wrap).
module down_counter_handshake
  import counter_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int INPUT_MAX = 10
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 last_o,
  output logic                 done_o
);

  localparam logic [WORD_SIZE-1:0] LOAD_VAL = WORD_SIZE'(INPUT_MAX);

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] data_q,  data_d;
  logic                 done_q,  done_d;
  logic                 beat;

  // State, index and done registers; synchronous reset clears all of them,
  // so a reset mid-sequence never produces a done pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eIDLE;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Next state: load on start, step down per handshake, finish (or wrap) at 0.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    done_d  = 1'b0;
    beat    = (state_q == eCOUNT) && ready_i;
    case (state_q)
      eIDLE: begin
        data_d = '0;
        if (start_i) begin
          state_d = eCOUNT;
          data_d  = LOAD_VAL;
        end
      end
      eCOUNT: begin
        // start_i is deliberately not looked at here: no mid-sequence reload.
        if (beat) begin
          if (data_q != '0) begin
            data_d = data_q - 1'b1;
          end else begin
            done_d = 1'b1;
`ifdef AUTO_RESTART_EN
            data_d  = LOAD_VAL;
`else
            state_d = eIDLE;
            data_d  = '0;
`endif
          end
        end
      end
      default: begin
        state_d = eIDLE;
        data_d  = '0;
      end
    endcase
  end

  // Outputs come straight from registers; last_o flags the zero beat.
  always_comb begin
    valid_o = (state_q == eCOUNT);
    data_o  = data_q;
    done_o  = done_q;
    last_o  = (state_q == eCOUNT) && (data_q == '0);
  end

endmodule : down_counter_handshake
